// File: rtl/task2.sv
// RC4 key-schedule engine: fills the external 256x8 S-memory with the identity, then runs the KSA swaps in place.
// Latency: 256 INIT cycles plus 8 cycles per KSA iteration (2304 cycles total), then idles in DONE until reset.
// Backpressure: none; the memory is assumed to accept one access per cycle, and every output is a flop.
module task2 (
    input  logic        clk,
    input  logic        reset,
    output logic        wren,
    input  logic [7:0]  q,
    output logic [7:0]  data,
    output logic [7:0]  address,
    input  logic [23:0] secret_key
);

    typedef enum logic [3:0] {
        S_INIT,
        S_RD_I,
        S_WT_I,
        S_CP_I,
        S_RD_J,
        S_WT_J,
        S_CP_J,
        S_WR_I,
        S_WR_J,
        S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] i, i_nxt;
    logic [7:0] j, j_nxt;
    logic [7:0] si, si_nxt;
    logic [7:0] sj, sj_nxt;
    logic [1:0] kidx, kidx_nxt;       // i mod 3, tracked incrementally
    logic [7:0] key_byte;
    logic       wren_nxt;
    logic [7:0] data_nxt;
    logic [7:0] address_nxt;

    // Key byte for the current i: MSB first, cycling every three indices.
    always_comb begin
        key_byte = secret_key[23:16];
        case (kidx)
            2'd1:    key_byte = secret_key[15:8];
            2'd2:    key_byte = secret_key[7:0];
            default: key_byte = secret_key[23:16];
        endcase
    end

    // Next-state and next-output logic; each state's memory access is registered on leaving it.
    always_comb begin
        state_nxt   = state;
        i_nxt       = i;
        j_nxt       = j;
        si_nxt      = si;
        sj_nxt      = sj;
        kidx_nxt    = kidx;
        wren_nxt    = 1'b0;
        data_nxt    = data;
        address_nxt = address;
        case (state)
            S_INIT: begin
                address_nxt = i;
                data_nxt    = i;
                wren_nxt    = 1'b1;
                if (i == 8'd255) begin
                    state_nxt = S_RD_I;
                    i_nxt     = 8'd0;
                    j_nxt     = 8'd0;
                    kidx_nxt  = 2'd0;
                end else begin
                    i_nxt = i + 8'd1;
                end
            end
            S_RD_I: begin
                address_nxt = i;
                state_nxt   = S_WT_I;
            end
            S_WT_I: state_nxt = S_CP_I;
            S_CP_I: begin
                // q now holds S[i]; the new j is formed from it directly.
                si_nxt    = q;
                j_nxt     = j + q + key_byte;
                state_nxt = S_RD_J;
            end
            S_RD_J: begin
                address_nxt = j;
                state_nxt   = S_WT_J;
            end
            S_WT_J: state_nxt = S_CP_J;
            S_CP_J: begin
                sj_nxt    = q;
                state_nxt = S_WR_I;
            end
            S_WR_I: begin
                address_nxt = i;
                data_nxt    = sj;
                wren_nxt    = 1'b1;
                state_nxt   = S_WR_J;
            end
            S_WR_J: begin
                // When i == j both writes hit one location with the same value.
                address_nxt = j;
                data_nxt    = si;
                wren_nxt    = 1'b1;
                if (i == 8'd255) begin
                    state_nxt = S_DONE;
                end else begin
                    i_nxt     = i + 8'd1;
                    kidx_nxt  = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                    state_nxt = S_RD_I;
                end
            end
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_INIT;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_INIT;
            i       <= 8'd0;
            j       <= 8'd0;
            si      <= 8'd0;
            sj      <= 8'd0;
            kidx    <= 2'd0;
            wren    <= 1'b0;
            data    <= 8'd0;
            address <= 8'd0;
        end else begin
            state   <= state_nxt;
            i       <= i_nxt;
            j       <= j_nxt;
            si      <= si_nxt;
            sj      <= sj_nxt;
            kidx    <= kidx_nxt;
            wren    <= wren_nxt;
            data    <= data_nxt;
            address <= address_nxt;
        end
    end

endmodule

// File: tb/tb_task2.sv
// Bench for task2: drives it against a synchronous 256x8 memory model and a software RC4 KSA reference.
// Latency: whole runs of 2304 cycles plus a quiet tail are observed per key.
// Backpressure: not applicable; the memory model answers every cycle.
module tb_task2;

    logic        clk = 1'b0;
    logic        reset;
    logic        wren;
    logic [7:0]  q;
    logic [7:0]  data;
    logic [7:0]  address;
    logic [23:0] secret_key;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_s [256];
    logic       scramble = 1'b0;

    localparam int LAST_EDGE = 2304 + 110;

    always #5 clk = ~clk;

    task2 dut (
        .clk        (clk),
        .reset      (reset),
        .wren       (wren),
        .q          (q),
        .data       (data),
        .address    (address),
        .secret_key (secret_key)
    );

    // Synchronous memory, one-cycle read latency; scramble fills it with junk so INIT must do the work.
    always @(posedge clk) begin
        if (scramble) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'($urandom);
        end else if (wren === 1'b1) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Plain software RC4 key schedule.
    task automatic compute_ref(input logic [23:0] key);
        logic [7:0] kb [3];
        int         jj;
        logic [7:0] t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            jj = (jj + int'(ref_s[ii]) + int'(kb[ii % 3])) % 256;
            t = ref_s[ii];
            ref_s[ii] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    // Expected write-enable after edge e counted from reset release: 256 INIT writes,
    // then the last two cycles of every 8-cycle iteration, then silence.
    function automatic logic exp_wren(input int e);
        if (e >= 1 && e <= 256) return 1'b1;
        if (e >= 257 && e <= 2304 && ((e - 257) % 8) >= 6) return 1'b1;
        return 1'b0;
    endfunction

    // Runs from edge start_e to the end of the quiet tail, checking INIT values,
    // the write schedule, the first swap, and the final memory image.
    task automatic ksa_run_and_check(input int start_e, input logic [23:0] key, input string name);
        int         bad_w;
        int         bad_i;
        int         bad_m;
        logic [7:0] j1;
        compute_ref(key);
        j1    = key[23:16];
        bad_w = 0;
        bad_i = 0;
        bad_m = 0;
        for (int e = start_e; e <= LAST_EDGE; e++) begin
            tick();
            if (wren !== exp_wren(e)) begin
                if (bad_w == 0)
                    $display("FAIL %s wren_sched edge %0d: got %b want %b", name, e, wren, exp_wren(e));
                bad_w++;
            end
            if (e <= 256 && {address, data} !== {8'(e - 1), 8'(e - 1)}) begin
                if (bad_i == 0)
                    $display("FAIL %s init_fill edge %0d: got addr %0d data %0d want %0d", name, e, address, data, e - 1);
                bad_i++;
            end
            if (e == 263) begin
                checks++;
                if ({address, data} !== {8'd0, j1}) begin
                    errors++;
                    $display("FAIL %s first_wr_i: got addr %h data %h want addr 00 data %h", name, address, data, j1);
                end
            end
            if (e == 264) begin
                checks++;
                if ({address, data} !== {j1, 8'd0}) begin
                    errors++;
                    $display("FAIL %s first_wr_j: got addr %h data %h want addr %h data 00", name, address, data, j1);
                end
            end
        end
        checks++;
        if (bad_w != 0) begin
            errors++;
            $display("FAIL %s wren_schedule: %0d bad cycles, want 0", name, bad_w);
        end
        if (start_e <= 256) begin
            checks++;
            if (bad_i != 0) begin
                errors++;
                $display("FAIL %s init_sequence: %0d bad cycles, want 0", name, bad_i);
            end
        end
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== ref_s[k]) begin
                if (bad_m == 0)
                    $display("FAIL %s final_s[%0d]: got %h want %h", name, k, mem[k], ref_s[k]);
                bad_m++;
            end
        end
        checks++;
        if (bad_m != 0) begin
            errors++;
            $display("FAIL %s final_s: %0d bytes differ, want 0", name, bad_m);
        end
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        scramble = 1'b1;
        tick();
        scramble = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        secret_key = 24'h000249;
        reset      = 1'b0;
        scramble   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            scramble = 1'b0;
            checks++;
            if ({wren, address, data} !== 17'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got wren %b addr %h data %h want 0/00/00", c, wren, address, data);
            end
        end
    endtask

    task automatic test_init();
        reset = 1'b1;
        for (int e = 1; e <= 256; e++) begin
            tick();
            checks++;
            if ({wren, address, data} !== {1'b1, 8'(e - 1), 8'(e - 1)}) begin
                errors++;
                $display("FAIL init_write %0d: got wren %b addr %h data %h", e - 1, wren, address, data);
            end
        end
    endtask

    task automatic test_ksa_known();
        ksa_run_and_check(257, 24'h000249, "key000249");
    endtask

    task automatic test_wrap();
        int   bad;
        logic seen [256];
        secret_key = 24'hFFFFFF;
        apply_reset();
        reset = 1'b1;
        ksa_run_and_check(1, 24'hFFFFFF, "keyFFFFFF");
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (seen[mem[k]]) bad++;
            seen[mem[k]] = 1'b1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL permutation: %0d duplicate values, want 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        logic [23:0] key;
        key        = 24'($urandom);
        secret_key = key;
        apply_reset();
        reset = 1'b1;
        // Edge 1057 starts iteration i=100; abort a few cycles into it.
        for (int e = 1; e <= 1060; e++) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({wren, address, data} !== 17'd0) begin
            errors++;
            $display("FAIL midksa_reset: got wren %b addr %h data %h want 0/00/00", wren, address, data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({wren, address, data} !== {1'b1, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL restart_init: got wren %b addr %h data %h want 1/00/00", wren, address, data);
        end
        ksa_run_and_check(2, key, "midreset");
    endtask

    task automatic test_random_keys();
        logic [23:0] key;
        for (int n = 0; n < 2; n++) begin
            key        = 24'($urandom);
            secret_key = key;
            apply_reset();
            reset = 1'b1;
            ksa_run_and_check(1, key, "randkey");
        end
    endtask

    initial begin
        reset      = 1'b0;
        secret_key = 24'h000249;
        @(negedge clk);
        test_reset();
        test_init();
        test_ksa_known();
        test_wrap();
        test_mid_reset();
        test_random_keys();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
